key_encoder_ctrl: RTL

Sequencer for the key encoder datapath. It runs two phases. In the load phase, keyword bytes are streamed from the host into the encoder's 80-bit word store. In the search phase, search keys are issued, the encoder's address/code result is captured, and it is returned over a valid/ready response channel. It sits between the speech front-end/host and the key encoder, and owns the encoder's ice/sce/ls/datain controls exclusively.

---
 rtl/key_encoder_ctrl_if.sv | 44 ++++
 rtl/key_encoder_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_encoder_ctrl_if.sv
// -----------------------------------------------------------------------------
// key_encoder_ctrl_if
// Host-side channels of the key encoder sequencer.
//   ld_*   : keyword byte stream (valid/ready, ld_last marks an early end)
//   srch_* : search request (valid/ready)
//   rsp_*  : search result (valid/ready), addr/code/hit payload
// Modports:
//   master : host / speech front-end side
//   slave  : key_encoder_ctrl side
// -----------------------------------------------------------------------------
interface key_encoder_ctrl_if;
  logic       ld_valid;
  logic       ld_ready;
  logic [7:0] ld_data;
  logic       ld_last;

  logic       srch_valid;
  logic       srch_ready;
  logic [7:0] srch_key;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_addr;
  logic [7:0] rsp_code;
  logic       rsp_hit;

  modport master (
    output ld_valid, ld_data, ld_last,
    input  ld_ready,
    output srch_valid, srch_key,
    input  srch_ready,
    input  rsp_valid, rsp_addr, rsp_code, rsp_hit,
    output rsp_ready
  );

  modport slave (
    input  ld_valid, ld_data, ld_last,
    output ld_ready,
    input  srch_valid, srch_key,
    output srch_ready,
    output rsp_valid, rsp_addr, rsp_code, rsp_hit,
    input  rsp_ready
  );
endinterface

// File: rtl/key_encoder_ctrl.sv
// -----------------------------------------------------------------------------
// key_encoder_ctrl
// Sequencer for the key encoder datapath. A load phase streams keyword bytes
// into the encoder word store; a search phase issues one key at a time, waits
// the encoder latency, captures add/out and returns them on the response
// channel. This block is the only driver of the encoder ice/sce/ls/datain.
//
// Ports:
//   clk, rst_n      : system clock, async active-low reset
//   host (slave)    : ld_*, srch_*, rsp_* channels
//   start_load      : pulse, begins a load (honoured in IDLE/READY only)
//   load_done       : level, word store loaded and searches permitted
//   load_cnt        : bytes loaded in the current/last load phase
//   enc_ice/sce/ls  : encoder input enable / search enable / load-search select
//   enc_datain      : encoder data input (load byte or search key)
//   enc_add/enc_out : encoder match address / code output
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, encoder untouched, no load yet
// LOAD  | accepting keyword bytes into the word store
// READY | store loaded, waiting for a search request
// ISSUE | search enable pulse, key on enc_datain
// WAIT  | encoder latency down-count, key held
// RESP  | result presented until the host accepts it
// -----------------------------------------------------------------------------
module key_encoder_ctrl #(
  parameter int         DEPTH     = 10,
  parameter int         SRCH_LAT  = 2,
  parameter logic [7:0] MISS_ADDR = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  key_encoder_ctrl_if.slave    host,
  input  logic                 start_load,
  output logic                 load_done,
  output logic                 enc_ice,
  output logic                 enc_sce,
  output logic                 enc_ls,
  output logic [7:0]           enc_datain,
  input  logic [7:0]           enc_add,
  input  logic [7:0]           enc_out,
  output logic [3:0]           load_cnt
);

  localparam logic [3:0] DEPTH_C   = 4'(DEPTH);
  localparam logic [3:0] LAST_C    = 4'(DEPTH - 1);
  localparam logic [3:0] WAIT_INIT = 4'(SRCH_LAT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READY = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic       ld_ready;
  logic       srch_ready;
  logic       rsp_valid;
  logic       ld_hs;
  logic       srch_hs;
  logic       load_start;
  logic       load_end;
  logic       wait_done;

  logic [3:0] wait_cnt;
  logic       enc_ls_q;
  logic [7:0] datain_q;
  logic [7:0] rsp_addr_q;
  logic [7:0] rsp_code_q;
  logic       rsp_hit_q;
  logic       load_done_q;
  logic [3:0] load_cnt_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and handshake decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    ld_ready   = 1'b0;
    srch_ready = 1'b0;
    rsp_valid  = 1'b0;
    enc_sce    = 1'b0;
    ld_hs      = 1'b0;
    srch_hs    = 1'b0;
    load_start = 1'b0;
    load_end   = 1'b0;
    wait_done  = 1'b0;

    case (state)
      IDLE: begin
        if (start_load) begin
          state_nxt  = LOAD;
          load_start = 1'b1;
        end
      end

      LOAD: begin
        // Guard keeps the store from ever taking a byte past DEPTH.
        ld_ready = (load_cnt_q != DEPTH_C);
        ld_hs    = host.ld_valid && ld_ready;
        if (ld_hs && (host.ld_last || (load_cnt_q == LAST_C))) begin
          state_nxt = READY;
          load_end  = 1'b1;
        end
      end

      READY: begin
        // A new load wins over a search offered in the same cycle.
        if (start_load) begin
          state_nxt  = LOAD;
          load_start = 1'b1;
        end else begin
          srch_ready = 1'b1;
          srch_hs    = host.srch_valid;
          if (srch_hs) begin
            state_nxt = ISSUE;
          end
        end
      end

      ISSUE: begin
        enc_sce   = 1'b1;
        state_nxt = WAIT;
      end

      WAIT: begin
        if (wait_cnt == 4'd0) begin
          wait_done = 1'b1;
          state_nxt = RESP;
        end
      end

      RESP: begin
        rsp_valid = 1'b1;
        if (host.rsp_ready) begin
          state_nxt = READY;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_q  <= 4'd0;
      load_done_q <= 1'b0;
      datain_q    <= 8'd0;
      enc_ls_q    <= 1'b0;
      wait_cnt    <= 4'd0;
      rsp_addr_q  <= 8'd0;
      rsp_code_q  <= 8'd0;
      rsp_hit_q   <= 1'b0;
    end else begin
      // ls stays high for one cycle after leaving LOAD so the last byte,
      // presented on the exit edge, is still written as a load.
      enc_ls_q <= (state_nxt == LOAD) || (state == LOAD);

      if (load_start) begin
        load_cnt_q  <= 4'd0;
        load_done_q <= 1'b0;
      end else if (ld_hs) begin
        load_cnt_q <= load_cnt_q + 4'd1;
        if (load_end) begin
          load_done_q <= 1'b1;
        end
      end

      if (ld_hs) begin
        datain_q <= host.ld_data;
      end else if (srch_hs) begin
        datain_q <= host.srch_key;
      end

      if (state == ISSUE) begin
        wait_cnt <= WAIT_INIT;
      end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      if (wait_done) begin
        rsp_addr_q <= enc_add;
        rsp_code_q <= enc_out;
        rsp_hit_q  <= (enc_add != MISS_ADDR);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The only way back to IDLE is reset, so ice stays up once a load begins.
  assign enc_ice    = (state != IDLE);
  assign enc_ls     = enc_ls_q;
  assign enc_datain = datain_q;
  assign load_done  = load_done_q;
  assign load_cnt   = load_cnt_q;

  assign host.ld_ready   = ld_ready;
  assign host.srch_ready = srch_ready;
  assign host.rsp_valid  = rsp_valid;
  assign host.rsp_addr   = rsp_addr_q;
  assign host.rsp_code   = rsp_code_q;
  assign host.rsp_hit    = rsp_hit_q;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_sce_not_in_load: assert property (@(posedge clk) disable iff (!rst_n)
    !(enc_sce && enc_ls));

  a_no_byte_past_depth: assert property (@(posedge clk) disable iff (!rst_n)
    !(ld_ready && (load_cnt_q == DEPTH_C)));

  a_one_search_in_flight: assert property (@(posedge clk) disable iff (!rst_n)
    !(srch_ready && ((state == ISSUE) || (state == WAIT) || (state == RESP))));

endmodule
